prog_loader: RTL and testbench

//  Writer side of instruction memory: receives a byte stream (length header, program words, checksum),

---
 rtl/prog_loader_pkg.sv | 42 ++++
 rtl/pl_byte_asm.sv | 43 ++++
 rtl/prog_loader.sv | 208 ++++++++++++++++++++
 tb/tb_prog_loader.sv | 324 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/prog_loader_pkg.sv
// ---------------------------------------------------------------------------
// prog_loader_pkg
// Shared definitions for the instruction-memory program loader:
//   - loader FSM state encoding
//   - error codes reported on err_code
//   - RV32 base opcodes accepted by the optional opcode screen
//   - op_is_legal(): opcode screen helper
// ---------------------------------------------------------------------------
package prog_loader_pkg;

    typedef enum logic [2:0] {
        ST_HDR     = 3'd0,
        ST_PAYLOAD = 3'd1,
        ST_WRITE   = 3'd2,
        ST_CHK     = 3'd3,
        ST_DONE    = 3'd4,
        ST_ERR     = 3'd5
    } state_e;

    localparam logic [1:0] ERR_NONE   = 2'd0;
    localparam logic [1:0] ERR_LEN    = 2'd1;
    localparam logic [1:0] ERR_CKSUM  = 2'd2;
    localparam logic [1:0] ERR_OPCODE = 2'd3;

    localparam logic [6:0] OP_R   = 7'h33;
    localparam logic [6:0] OP_I   = 7'h13;
    localparam logic [6:0] OP_LW  = 7'h03;
    localparam logic [6:0] OP_SW  = 7'h23;
    localparam logic [6:0] OP_BEQ = 7'h63;
    localparam logic [6:0] OP_JAL = 7'h6F;

    // True when the 7-bit opcode field belongs to the supported instruction set.
    function automatic logic op_is_legal(input logic [6:0] op);
        logic ok;
        case (op)
            OP_R, OP_I, OP_LW, OP_SW, OP_BEQ, OP_JAL: ok = 1'b1;
            default:                                  ok = 1'b0;
        endcase
        return ok;
    endfunction

endpackage

// File: rtl/pl_byte_asm.sv
// ---------------------------------------------------------------------------
// pl_byte_asm
// Little-endian byte-to-word assembler. The first accepted byte of a group
// lands in word_o[7:0]; on the 4th byte word_valid_o pulses (combinationally,
// same cycle as that byte) and word_o carries the complete word.
// Ports:
//   clk, reset    clock, synchronous active-high reset
//   byte_valid_i  byte_i is consumed this cycle
//   byte_i        stream byte
//   word_o        assembled word (valid when word_valid_o)
//   word_valid_o  4th byte of a word is being consumed this cycle
// ---------------------------------------------------------------------------
module pl_byte_asm (
    input  logic        clk,
    input  logic        reset,
    input  logic        byte_valid_i,
    input  logic [7:0]  byte_i,
    output logic [31:0] word_o,
    output logic        word_valid_o
);

    // Only the three earlier bytes need storage; the 4th arrives live.
    logic [23:0] sr_q;
    logic [1:0]  cnt_q;

    assign word_o       = {byte_i, sr_q};
    assign word_valid_o = byte_valid_i && (cnt_q == 2'd3);

    // Shift register and byte counter; counter wraps to 0 after each word.
    always_ff @(posedge clk) begin
        if (reset) begin
            sr_q  <= 24'h000000;
            cnt_q <= 2'd0;
        end else if (byte_valid_i) begin
            sr_q  <= {byte_i, sr_q[23:8]};
            cnt_q <= cnt_q + 2'd1;
        end else begin
            sr_q  <= sr_q;
            cnt_q <= cnt_q;
        end
    end

endmodule

// File: rtl/prog_loader.sv
// ---------------------------------------------------------------------------
// prog_loader
// Writer side of instruction memory. Consumes a byte stream made of a 4-byte
// little-endian word count N, 4*N payload bytes and one XOR checksum byte,
// writes each assembled word to BASE + 4*idx and reports BASE as the entry
// PC once the checksum matches.
// Optional feature: define PLOAD_OPCHK_EN to reject words whose opcode field
// is not a supported base opcode (err_code 3, word not written).
// Ports:
//   clk, reset            clock, synchronous active-high reset
//   in_valid/in_byte      byte source; in_ready = loader takes the byte
//   mem_we/addr/wdata     instruction-memory write request, held until
//   mem_ready             mem_ready completes it
//   done, err, err_code   sticky completion / abort status
//   entry_pc              BASE once done, else 0
//   word_count            words written so far
// ---------------------------------------------------------------------------
module prog_loader
    import prog_loader_pkg::*;
#(
    parameter logic [31:0] BASE      = 32'h28,
    parameter int unsigned MAX_WORDS = 64
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        in_valid,
    input  logic [7:0]  in_byte,
    output logic        in_ready,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic        mem_ready,
    output logic        done,
    output logic        err,
    output logic [1:0]  err_code,
    output logic [31:0] entry_pc,
    output logic [15:0] word_count
);

    state_e      state_q, state_d;
    logic [31:0] n_q, n_d;
    logic [7:0]  acc_q, acc_d;
    logic        in_ready_q, in_ready_d;
    logic        mem_we_q, mem_we_d;
    logic [31:0] mem_addr_q, mem_addr_d;
    logic [31:0] mem_wdata_q, mem_wdata_d;
    logic        done_q, done_d;
    logic        err_q, err_d;
    logic [1:0]  err_code_q, err_code_d;
    logic [31:0] entry_pc_q, entry_pc_d;
    // word_count also serves as the write index: both advance on every completed write.
    logic [15:0] word_count_q, word_count_d;

    logic        take_s;
    logic        asm_en_s;
    logic [31:0] asm_word_s;
    logic        asm_valid_s;
    logic        op_bad_s;

    assign take_s   = in_valid && in_ready_q;
    // The assembler only sees header and payload bytes, never the checksum byte.
    assign asm_en_s = take_s && ((state_q == ST_HDR) || (state_q == ST_PAYLOAD));

    pl_byte_asm u_asm (
        .clk          (clk),
        .reset        (reset),
        .byte_valid_i (asm_en_s),
        .byte_i       (in_byte),
        .word_o       (asm_word_s),
        .word_valid_o (asm_valid_s)
    );

`ifdef PLOAD_OPCHK_EN
    assign op_bad_s = !op_is_legal(asm_word_s[6:0]);
`else
    assign op_bad_s = 1'b0;
`endif

    // Next-state and registered-output computation.
    always_comb begin
        state_d      = state_q;
        n_d          = n_q;
        acc_d        = acc_q;
        mem_we_d     = mem_we_q;
        mem_addr_d   = mem_addr_q;
        mem_wdata_d  = mem_wdata_q;
        done_d       = done_q;
        err_d        = err_q;
        err_code_d   = err_code_q;
        entry_pc_d   = entry_pc_q;
        word_count_d = word_count_q;

        case (state_q)
            ST_HDR: begin
                if (asm_valid_s) begin
                    if ((asm_word_s == 32'd0) || (asm_word_s > 32'(MAX_WORDS))) begin
                        state_d    = ST_ERR;
                        err_d      = 1'b1;
                        err_code_d = ERR_LEN;
                    end else begin
                        state_d = ST_PAYLOAD;
                        n_d     = asm_word_s;
                    end
                end else begin
                    state_d = ST_HDR;
                end
            end
            ST_PAYLOAD: begin
                if (take_s) begin
                    acc_d = acc_q ^ in_byte;
                end else begin
                    acc_d = acc_q;
                end
                if (asm_valid_s && op_bad_s) begin
                    state_d    = ST_ERR;
                    err_d      = 1'b1;
                    err_code_d = ERR_OPCODE;
                end else if (asm_valid_s) begin
                    state_d     = ST_WRITE;
                    mem_we_d    = 1'b1;
                    mem_wdata_d = asm_word_s;
                    mem_addr_d  = BASE + {14'd0, word_count_q, 2'b00};
                end else begin
                    state_d = ST_PAYLOAD;
                end
            end
            ST_WRITE: begin
                if (mem_ready) begin
                    mem_we_d     = 1'b0;
                    word_count_d = word_count_q + 16'd1;
                    if (({16'd0, word_count_q} + 32'd1) == n_q) begin
                        state_d = ST_CHK;
                    end else begin
                        state_d = ST_PAYLOAD;
                    end
                end else begin
                    state_d = ST_WRITE;
                end
            end
            ST_CHK: begin
                if (take_s && (in_byte == acc_q)) begin
                    state_d    = ST_DONE;
                    done_d     = 1'b1;
                    entry_pc_d = BASE;
                end else if (take_s) begin
                    state_d    = ST_ERR;
                    err_d      = 1'b1;
                    err_code_d = ERR_CKSUM;
                end else begin
                    state_d = ST_CHK;
                end
            end
            ST_DONE: begin
                state_d = ST_DONE;
            end
            ST_ERR: begin
                state_d = ST_ERR;
            end
            default: begin
                state_d = ST_HDR;
            end
        endcase

        in_ready_d = (state_d == ST_HDR) || (state_d == ST_PAYLOAD) || (state_d == ST_CHK);
    end

    // State and output registers; reset overrides every state including WRITE.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= ST_HDR;
            n_q          <= 32'd0;
            acc_q        <= 8'h00;
            in_ready_q   <= 1'b1;
            mem_we_q     <= 1'b0;
            mem_addr_q   <= 32'd0;
            mem_wdata_q  <= 32'd0;
            done_q       <= 1'b0;
            err_q        <= 1'b0;
            err_code_q   <= ERR_NONE;
            entry_pc_q   <= 32'd0;
            word_count_q <= 16'd0;
        end else begin
            state_q      <= state_d;
            n_q          <= n_d;
            acc_q        <= acc_d;
            in_ready_q   <= in_ready_d;
            mem_we_q     <= mem_we_d;
            mem_addr_q   <= mem_addr_d;
            mem_wdata_q  <= mem_wdata_d;
            done_q       <= done_d;
            err_q        <= err_d;
            err_code_q   <= err_code_d;
            entry_pc_q   <= entry_pc_d;
            word_count_q <= word_count_d;
        end
    end

    assign in_ready   = in_ready_q;
    assign mem_we     = mem_we_q;
    assign mem_addr   = mem_addr_q;
    assign mem_wdata  = mem_wdata_q;
    assign done       = done_q;
    assign err        = err_q;
    assign err_code   = err_code_q;
    assign entry_pc   = entry_pc_q;
    assign word_count = word_count_q;

endmodule

// File: tb/tb_prog_loader.sv
// ---------------------------------------------------------------------------
// tb_prog_loader
// Self-checking bench for prog_loader. Each load is described by a word
// count and a list of words; a reference model turns that into the byte
// stream to send, the expected memory writes (pushed into a scoreboard
// queue) and the expected final status. A monitor pops the queue on every
// completed memory write and also checks that stalled writes stay stable.
// ---------------------------------------------------------------------------
module tb_prog_loader;

    localparam logic [31:0] BASE = 32'h28;
    localparam int unsigned MAXW = 64;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        in_valid = 1'b0;
    logic [7:0]  in_byte = 8'h00;
    logic        in_ready;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_ready = 1'b1;
    logic        done;
    logic        err;
    logic [1:0]  err_code;
    logic [31:0] entry_pc;
    logic [15:0] word_count;

    prog_loader dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_byte(in_byte),
        .in_ready(in_ready), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_ready(mem_ready), .done(done), .err(err),
        .err_code(err_code), .entry_pc(entry_pc), .word_count(word_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
    } wr_t;

    wr_t         exp_q[$];
    logic [31:0] wq[$];
    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;
    int          rdy_mode = 0;   // 0 always ready, 1 random, 2 three-cycle stall, 3 ready for first write only
    int          wr_seen = 0;
    logic [6:0]  ops [6] = '{7'h33, 7'h13, 7'h03, 7'h23, 7'h63, 7'h6F};

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    function automatic bit opcode_ok(input logic [31:0] w);
`ifdef PLOAD_OPCHK_EN
        return w[6:0] inside {7'h33, 7'h13, 7'h03, 7'h23, 7'h63, 7'h6F};
`else
        return 1'b1;
`endif
    endfunction

    function automatic logic [31:0] rand_word(input bit allow_bad);
        logic [31:0] w;
        w = $urandom();
        w[6:0] = ops[$urandom_range(0, 5)];
        if (allow_bad && ($urandom_range(0, 7) == 0)) w[6:0] = 7'h7F;
        return w;
    endfunction

    // mem_ready driver, updated just after each active edge.
    initial begin
        int low_cnt;
        low_cnt = 0;
        forever begin
            @(posedge clk);
            #2;
            case (rdy_mode)
                0: mem_ready = 1'b1;
                1: mem_ready = 1'($urandom_range(0, 1));
                2: begin
                    if (mem_we && low_cnt < 3) begin
                        mem_ready = 1'b0;
                        low_cnt++;
                    end else begin
                        mem_ready = 1'b1;
                        if (!mem_we) low_cnt = 0;
                    end
                end
                3: mem_ready = (wr_seen < 1);
                default: mem_ready = 1'b1;
            endcase
        end
    end

    // Monitor: scoreboard pop on each completed write, plus stall stability.
    initial begin
        logic        prev_stall;
        logic [31:0] prev_a, prev_d;
        int          hold_cnt;
        wr_t         e;
        prev_stall = 1'b0; prev_a = 32'd0; prev_d = 32'd0; hold_cnt = 0;
        forever begin
            @(negedge clk);
            if (reset) begin
                prev_stall = 1'b0;
                hold_cnt = 0;
            end else begin
                if (prev_stall) begin
                    check("stall_we_held", {31'd0, mem_we}, 32'd1);
                    check("stall_addr_held", mem_addr, prev_a);
                    check("stall_data_held", mem_wdata, prev_d);
                end
                if (mem_we) begin
                    check("in_ready_low_in_write", {31'd0, in_ready}, 32'd0);
                    hold_cnt++;
                end
                if (mem_we && mem_ready) begin
                    if (exp_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_write actual=%h/%h required=no write", mem_addr, mem_wdata);
                    end else begin
                        e = exp_q.pop_front();
                        check("write_addr", mem_addr, e.addr);
                        check("write_data", mem_wdata, e.data);
                    end
                    if (rdy_mode == 2) check("stall_cycles", hold_cnt, 32'd4);
                    wr_seen++;
                    hold_cnt = 0;
                end
                prev_stall = mem_we && !mem_ready;
                prev_a = mem_addr;
                prev_d = mem_wdata;
            end
        end
    end

    // Offer one byte, holding it until the loader is ready; returns on the
    // falling edge after the byte was consumed.
    task automatic send_byte(input logic [7:0] b, input int gap);
        int k;
        in_valid = 1'b0;
        repeat (gap) @(negedge clk);
        in_valid = 1'b1;
        in_byte  = b;
        k = 0;
        while (!in_ready && k < 200) begin
            @(negedge clk);
            k++;
        end
        if (k >= 200) begin
            checks++;
            errors++;
            $display("FAIL byte_accept_timeout actual=in_ready low 200 cycles required=accept");
        end
        @(negedge clk);
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        in_valid = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        exp_q.delete();
        wr_seen = 0;
    endtask

    task automatic check_idle(input string tag);
        check({tag, "_in_ready"}, {31'd0, in_ready}, 32'd1);
        check({tag, "_mem_we"}, {31'd0, mem_we}, 32'd0);
        check({tag, "_mem_addr"}, mem_addr, 32'd0);
        check({tag, "_mem_wdata"}, mem_wdata, 32'd0);
        check({tag, "_done"}, {31'd0, done}, 32'd0);
        check({tag, "_err"}, {31'd0, err}, 32'd0);
        check({tag, "_err_code"}, {30'd0, err_code}, 32'd0);
        check({tag, "_entry_pc"}, entry_pc, 32'd0);
        check({tag, "_word_count"}, {16'd0, word_count}, 32'd0);
    endtask

    // Reference model + driver for one complete load using words in wq.
    task automatic run_load(input logic [31:0] n, input bit bad_ck, input bit gaps, input bit tp);
        logic [7:0]  bq[$];
        logic [7:0]  x, ck;
        logic [31:0] w;
        int          code, wc, t0;
        wr_t         e;
        x = 8'h00; code = 0; wc = 0;
        for (int i = 0; i < 4; i++) bq.push_back(8'((n >> (8 * i)) & 32'hFF));
        if (n == 32'd0 || n > MAXW) begin
            code = 1;
        end else begin
            for (int i = 0; i < int'(n); i++) begin
                w = wq[i];
                for (int j = 0; j < 4; j++) begin
                    bq.push_back(8'((w >> (8 * j)) & 32'hFF));
                    x = x ^ 8'((w >> (8 * j)) & 32'hFF);
                end
                if (!opcode_ok(w)) begin
                    code = 3;
                    break;
                end
                e.addr = BASE + 32'(4 * i);
                e.data = w;
                exp_q.push_back(e);
                wc++;
            end
            if (code == 0) begin
                ck = bad_ck ? (x ^ 8'($urandom_range(1, 255))) : x;
                bq.push_back(ck);
                if (bad_ck) code = 2;
            end
        end
        t0 = cyc;
        foreach (bq[i]) send_byte(bq[i], gaps ? $urandom_range(0, 2) : 0);
        in_valid = 1'b0;
        if (tp) check("throughput_cycles", 32'(cyc - t0), 5 * n + 32'd5);
        check("done_on_time", {31'd0, done}, {31'd0, code == 0});
        check("err_on_time", {31'd0, err}, {31'd0, code != 0});
        repeat (2) @(negedge clk);
        check("done_sticky", {31'd0, done}, {31'd0, code == 0});
        check("err_sticky", {31'd0, err}, {31'd0, code != 0});
        check("err_code", {30'd0, err_code}, 32'(code));
        check("entry_pc", entry_pc, (code == 0) ? BASE : 32'd0);
        check("word_count", {16'd0, word_count}, 32'(wc));
        check("in_ready_final", {31'd0, in_ready}, 32'd0);
        check("writes_outstanding", 32'(exp_q.size()), 32'd0);
    endtask

    initial begin
        logic [31:0] n;
        // Reset state.
        repeat (3) @(negedge clk);
        reset = 1'b0;
        check_idle("reset");

        // Two-word program at full speed.
        wq = '{32'h00A00093, 32'h00108133};
        run_load(32'd2, 1'b0, 1'b0, 1'b1);

        // Length errors: zero, one above limit, large value with small low bits.
        do_reset(); run_load(32'd0, 1'b0, 1'b0, 1'b0);
        do_reset(); run_load(32'd65, 1'b0, 1'b0, 1'b0);
        do_reset(); run_load(32'h0100_0002, 1'b0, 1'b0, 1'b0);

        // Largest legal program with random ready and gaps.
        do_reset();
        wq.delete();
        for (int i = 0; i < 64; i++) wq.push_back(rand_word(1'b0));
        rdy_mode = 1;
        run_load(32'd64, 1'b0, 1'b1, 1'b0);
        rdy_mode = 0;

        // Bad checksum on a single valid word.
        do_reset();
        wq = '{32'h00A00093};
        run_load(32'd1, 1'b1, 1'b0, 1'b0);

        // Three-cycle memory stall on every write.
        do_reset();
        wq = '{32'h00000013, 32'h00208023, 32'h0000006F};
        rdy_mode = 2;
        run_load(32'd3, 1'b0, 1'b0, 1'b0);
        rdy_mode = 0;

        // Reset while the second word waits in WRITE.
        do_reset();
        rdy_mode = 3;
        wq = '{32'h00500113, 32'h002081B3};
        begin
            wr_t e;
            e.addr = BASE; e.data = wq[0];
            exp_q.push_back(e);
        end
        n = 32'd2;
        for (int i = 0; i < 4; i++) send_byte(8'((n >> (8 * i)) & 32'hFF), 0);
        for (int i = 0; i < 8; i++) send_byte(8'((wq[i / 4] >> (8 * (i % 4))) & 32'hFF), 0);
        in_valid = 1'b0;
        check("rst_pre_we", {31'd0, mem_we}, 32'd1);
        check("rst_pre_addr", mem_addr, BASE + 32'd4);
        check("rst_pre_wc", {16'd0, word_count}, 32'd1);
        reset = 1'b1;
        @(negedge clk);
        check_idle("rst_in_write");
        reset = 1'b0;
        rdy_mode = 0;
        exp_q.delete();

        // Word with an unsupported opcode.
        do_reset();
        wq = '{32'h0000007F, 32'h00000013};
        run_load(32'd2, 1'b0, 1'b0, 1'b0);

        // Randomized loads.
        for (int t = 0; t < 20; t++) begin
            do_reset();
            wq.delete();
            n = 32'($urandom_range(1, 8));
            for (int i = 0; i < int'(n); i++) wq.push_back(rand_word(1'b1));
            rdy_mode = $urandom_range(0, 1);
            run_load(n, ($urandom_range(0, 3) == 0), 1'($urandom_range(0, 1)), 1'b0);
            rdy_mode = 0;
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    // Global watchdog so the run always ends.
    initial begin
        #2000000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

endmodule
